// File: rtl/score_display_scanner.sv
// rtl/score_display_scanner.sv - BCD conversion of two hand totals and 4-digit scan feeder
// for the board's BCD-to-7-segment decoder.
module score_display_scanner #(
   parameter int         REFRESH_DIV = 100000,
   parameter int         CNT_W       = 17,
   parameter logic [4:0] BLANK_CODE  = 5'b11111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [4:0] player_total,
   input  logic [4:0] dealer_total,
   output logic [4:0] digit_code,
   output logic [3:0] an,
   output logic       busy,
   output logic       valid
);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t     state, state_nxt;
   logic [1:0] iter, iter_nxt;
   logic       busy_nxt, valid_nxt;

   logic [4:0] p_work, p_work_nxt, d_work, d_work_nxt;
   logic [1:0] p_tens, p_tens_nxt, d_tens, d_tens_nxt;

   logic [3:0] p_ones_disp, p_ones_disp_nxt, d_ones_disp, d_ones_disp_nxt;
   logic [1:0] p_tens_disp, p_tens_disp_nxt, d_tens_disp, d_tens_disp_nxt;

   logic [CNT_W-1:0] refresh_cnt;
   logic [1:0]       scan_idx;
   logic [4:0]       sel_code;
   logic [3:0]       sel_an;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         iter        <= 2'd0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         p_work      <= 5'd0;
         d_work      <= 5'd0;
         p_tens      <= 2'd0;
         d_tens      <= 2'd0;
         p_ones_disp <= 4'd0;
         d_ones_disp <= 4'd0;
         p_tens_disp <= 2'd0;
         d_tens_disp <= 2'd0;
      end else begin
         state       <= state_nxt;
         iter        <= iter_nxt;
         busy        <= busy_nxt;
         valid       <= valid_nxt;
         p_work      <= p_work_nxt;
         d_work      <= d_work_nxt;
         p_tens      <= p_tens_nxt;
         d_tens      <= d_tens_nxt;
         p_ones_disp <= p_ones_disp_nxt;
         d_ones_disp <= d_ones_disp_nxt;
         p_tens_disp <= p_tens_disp_nxt;
         d_tens_disp <= d_tens_disp_nxt;
      end
   end

   // Fixed four-pass subtract-10 loop; 31 needs only three passes, so the
   // fourth pass is a no-op that keeps the latency constant.
   always_comb begin
      state_nxt       = state;
      iter_nxt        = iter;
      busy_nxt        = busy;
      valid_nxt       = valid;
      p_work_nxt      = p_work;
      d_work_nxt      = d_work;
      p_tens_nxt      = p_tens;
      d_tens_nxt      = d_tens;
      p_ones_disp_nxt = p_ones_disp;
      d_ones_disp_nxt = d_ones_disp;
      p_tens_disp_nxt = p_tens_disp;
      d_tens_disp_nxt = d_tens_disp;
      case (state)
         IDLE: begin
            if (load) begin
               state_nxt  = CONVERT;
               iter_nxt   = 2'd0;
               busy_nxt   = 1'b1;
               p_work_nxt = player_total;
               d_work_nxt = dealer_total;
               p_tens_nxt = 2'd0;
               d_tens_nxt = 2'd0;
            end
         end
         CONVERT: begin
            if (p_work >= 5'd10) begin
               p_work_nxt = p_work - 5'd10;
               p_tens_nxt = p_tens + 2'd1;
            end
            if (d_work >= 5'd10) begin
               d_work_nxt = d_work - 5'd10;
               d_tens_nxt = d_tens + 2'd1;
            end
            iter_nxt = iter + 2'd1;
            if (iter == 2'd3) begin
               state_nxt       = IDLE;
               busy_nxt        = 1'b0;
               valid_nxt       = 1'b1;
               p_ones_disp_nxt = p_work[3:0];
               d_ones_disp_nxt = d_work[3:0];
               p_tens_disp_nxt = p_tens;
               d_tens_disp_nxt = d_tens;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         scan_idx    <= 2'd0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Tens digits of zero are blanked; ones digits always show.
   always_comb begin
      sel_code = BLANK_CODE;
      sel_an   = 4'b1111;
      case (scan_idx)
         2'd0: begin
            sel_code = {1'b0, p_ones_disp};
            sel_an   = 4'b1110;
         end
         2'd1: begin
            sel_code = (p_tens_disp == 2'd0) ? BLANK_CODE : {3'b000, p_tens_disp};
            sel_an   = 4'b1101;
         end
         2'd2: begin
            sel_code = {1'b0, d_ones_disp};
            sel_an   = 4'b1011;
         end
         default: begin
            sel_code = (d_tens_disp == 2'd0) ? BLANK_CODE : {3'b000, d_tens_disp};
            sel_an   = 4'b0111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !valid) begin
         an         <= 4'b1111;
         digit_code <= BLANK_CODE;
      end else begin
         an         <= sel_an;
         digit_code <= sel_code;
      end
   end

endmodule

// File: tb/tb_score_display_scanner.sv
// tb/tb_score_display_scanner.sv - scoreboard bench: expected digits queued per accepted load,
// monitor checks busy/valid timing and every scanned digit each cycle.
module tb_score_display_scanner;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [4:0] player_total = 5'd0;
   logic [4:0] dealer_total = 5'd0;
   logic [4:0] digit_code;
   logic [3:0] an;
   logic       busy;
   logic       valid;

   score_display_scanner #(.REFRESH_DIV(RD), .CNT_W(2), .BLANK_CODE(5'b11111)) dut (
      .clk(clk), .rst(rst), .load(load),
      .player_total(player_total), .dealer_total(dealer_total),
      .digit_code(digit_code), .an(an), .busy(busy), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef logic [3:0][4:0] codes_t;

   codes_t exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     ecnt = 0;
   int     last_acc = -100;

   always @(posedge clk) ecnt++;

   function automatic codes_t model(int p, int d);
      codes_t c;
      c[0] = 5'(p % 10);
      c[1] = (p / 10 == 0) ? 5'd31 : 5'(p / 10);
      c[2] = 5'(d % 10);
      c[3] = (d / 10 == 0) ? 5'd31 : 5'(d / 10);
      return c;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecnt);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   int     t = 0;
   codes_t cur, pend;
   bit     cur_valid = 0, pend_flag = 0, exp_valid = 0, prev_busy = 0;
   int     idx;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         t = 0;
         cur_valid = 0;
         pend_flag = 0;
         exp_valid = 0;
         prev_busy = 0;
         exp_q.delete();
         chk("rst_an", an, 15);
         chk("rst_code", digit_code, 31);
         chk("rst_busy", busy, 0);
         chk("rst_valid", valid, 0);
      end else begin
         t++;
         if (pend_flag) begin
            cur = pend;
            cur_valid = 1;
            pend_flag = 0;
         end
         if (ecnt == last_acc + 4) exp_valid = 1;
         chk("busy", busy, (ecnt >= last_acc && ecnt <= last_acc + 3) ? 1 : 0);
         chk("valid", valid, exp_valid ? 1 : 0);
         if (!cur_valid) begin
            chk("blank_an", an, 15);
            chk("blank_code", digit_code, 31);
         end else begin
            idx = ((t - 1) / RD) % 4;
            chk("scan_an", an, 15 & ~(1 << idx));
            chk("scan_code", digit_code, cur[idx]);
         end
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) chk("commit_expected", 0, 1);
            else begin
               pend = exp_q.pop_front();
               pend_flag = 1;
            end
         end
         prev_busy = busy;
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(int p, int d);
      @(negedge clk);
      player_total = 5'(p);
      dealer_total = 5'(d);
      load = 1'b1;
      if (ecnt + 1 - last_acc >= 5) begin
         exp_q.push_back(model(p, d));
         last_acc = ecnt + 1;
      end
      @(negedge clk);
      load = 1'b0;
      player_total = 5'($urandom_range(0, 31));
      dealer_total = 5'($urandom_range(0, 31));
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      rst = 1'b1;
      last_acc = -100;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tick(10);
      do_load(21, 17); tick(20);
      do_load(5, 0);   tick(20);
      do_load(21, 17); tick(1);
      do_load(9, 9);   tick(20);
      do_load(31, 30); tick(20);
      do_load(10, 19); tick(20);
      do_load(12, 25);
      do_reset(1);
      tick(10);
      do_load(0, 31);  tick(20);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
         else do_load($urandom_range(0, 31), $urandom_range(0, 31));
         tick($urandom_range(0, 20));
      end
      tick(25);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
